spi_flash_resp: RTL and testbench

SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

---
 rtl/spi_flash_resp.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_flash_resp.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_resp.sv
// SPI serial-flash responder supporting READ (0x03) and QUAD OUTPUT READ (0x6B).
// All SPI pins are oversampled on clk_i; the byte store is fetched one byte ahead.
module spi_flash_resp #(
   parameter int SYNC_STAGES  = 2,
   parameter int DUMMY_CYCLES = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        spi_clk_i,
   input  logic        spi_ss_i,
   input  logic        spi_dq0_i,
   input  logic        spi_dq1_i,
   input  logic        spi_dq2_i,
   input  logic        spi_dq3_i,
   output logic        spi_dq0_o,
   output logic        spi_dq1_o,
   output logic        spi_dq2_o,
   output logic        spi_dq3_o,
   output logic        spi_dq0_oe_o,
   output logic        spi_dq1_oe_o,
   output logic        spi_dq2_oe_o,
   output logic        spi_dq3_oe_o,
   output logic        mem_rd_o,
   output logic [23:0] mem_addr_o,
   input  logic [7:0]  mem_rdata_i,
   output logic        busy_o,
   output logic        cmd_err_o
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_e;

   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES > 0 ? DUMMY_CYCLES - 1 : 0);
   localparam logic [1:0] SETTLE     = 2'(SYNC_STAGES);

   // dq1..dq3 are output-only for the supported commands
   logic unused_dq_in;
   assign unused_dq_in = ^{spi_dq1_i, spi_dq2_i, spi_dq3_i};

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] dq0_sync_q, dq0_sync_d;
   logic                   sclk_prev_q, ss_prev_q;
   logic [1:0]             settle_q, settle_d;
   logic                   ss_armed_q, ss_armed_d;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [23:0] sr_q, sr_d;
   logic [23:0] addr_q, addr_d;
   logic        quad_q, quad_d;
   logic [7:0]  nxt_byte_q, nxt_byte_d;
   logic        rd_pend_q;
   logic [7:0]  out_sr_q, out_sr_d;
   logic [2:0]  out_cnt_q, out_cnt_d;
   logic [3:0]  dq_q, dq_d;
   logic [3:0]  oe_q, oe_d;
   logic        mem_rd_q, mem_rd_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic        cmd_err_q, cmd_err_d;

   logic sclk_s, ss_s, dq0_s;
   logic sclk_rise, sclk_fall, ss_fall, settle_done;
   logic [7:0]  cmd_byte, byte_src;
   logic [23:0] addr_rx;
   logic [2:0]  last_cnt;

   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s        = ss_sync_q[SYNC_STAGES-1];
   assign dq0_s       = dq0_sync_q[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign settle_done = (settle_q == SETTLE);
   // A fall only counts once SS has genuinely been seen high after reset
   assign ss_fall     = ss_armed_q & ss_prev_q & ~ss_s;

   assign cmd_byte = {sr_q[6:0], dq0_s};
   assign addr_rx  = {sr_q[22:0], dq0_s};
   assign byte_src = (out_cnt_q == 3'd0) ? nxt_byte_q : out_sr_q;
   assign last_cnt = quad_q ? 3'd1 : 3'd7;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
      dq0_sync_d  = {dq0_sync_q[SYNC_STAGES-2:0], spi_dq0_i};
      settle_d    = settle_done ? settle_q : settle_q + 2'd1;
      ss_armed_d  = ss_armed_q | (settle_done & ss_s);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      addr_d     = addr_q;
      quad_d     = quad_q;
      nxt_byte_d = rd_pend_q ? mem_rdata_i : nxt_byte_q;
      out_sr_d   = out_sr_q;
      out_cnt_d  = out_cnt_q;
      dq_d       = dq_q;
      oe_d       = oe_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      cmd_err_d  = 1'b0;

      if (state_q != IDLE && ss_s) begin
         state_d   = IDLE;
         cnt_d     = 8'd0;
         sr_d      = 24'd0;
         out_cnt_d = 3'd0;
         dq_d      = 4'd0;
         oe_d      = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ss_fall) begin
                  state_d = CMD;
                  cnt_d   = 8'd0;
                  sr_d    = 24'd0;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  sr_d  = addr_rx;
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == 8'd7) begin
                     cnt_d = 8'd0;
                     if (cmd_byte == 8'h03 || cmd_byte == 8'h6B) begin
                        state_d = ADDR;
                        quad_d  = (cmd_byte == 8'h6B);
                     end else begin
                        state_d   = IGNORE;
                        cmd_err_d = 1'b1;
                     end
                  end
               end
            end
            ADDR: begin
               if (sclk_rise) begin
                  sr_d  = addr_rx;
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == 8'd23) begin
                     cnt_d      = 8'd0;
                     out_cnt_d  = 3'd0;
                     addr_d     = addr_rx;
                     mem_rd_d   = 1'b1;
                     mem_addr_d = addr_rx;
                     state_d    = (quad_q && DUMMY_CYCLES > 0) ? DUMMY : DATA;
                  end
               end
            end
            DUMMY: begin
               if (sclk_rise) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == DUMMY_LAST) begin
                     cnt_d   = 8'd0;
                     state_d = DATA;
                  end
               end
            end
            DATA: begin
               // Shift out on each fall; the next byte is fetched during the last slot
               if (sclk_fall) begin
                  if (quad_q) begin
                     dq_d     = byte_src[7:4];
                     out_sr_d = {byte_src[3:0], 4'd0};
                     oe_d     = 4'b1111;
                  end else begin
                     dq_d     = {2'b00, byte_src[7], 1'b0};
                     out_sr_d = {byte_src[6:0], 1'b0};
                     oe_d     = 4'b0010;
                  end
                  if (out_cnt_q == last_cnt) begin
                     out_cnt_d  = 3'd0;
                     addr_d     = addr_q + 24'd1;
                     mem_rd_d   = 1'b1;
                     mem_addr_d = addr_q + 24'd1;
                  end else begin
                     out_cnt_d = out_cnt_q + 3'd1;
                  end
               end
            end
            IGNORE: begin
               oe_d = 4'd0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         dq0_sync_q  <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
         settle_q    <= 2'd0;
         ss_armed_q  <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         sr_q        <= 24'd0;
         addr_q      <= 24'd0;
         quad_q      <= 1'b0;
         nxt_byte_q  <= 8'd0;
         rd_pend_q   <= 1'b0;
         out_sr_q    <= 8'd0;
         out_cnt_q   <= 3'd0;
         dq_q        <= 4'd0;
         oe_q        <= 4'd0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= 24'd0;
         cmd_err_q   <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         ss_sync_q   <= ss_sync_d;
         dq0_sync_q  <= dq0_sync_d;
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
         settle_q    <= settle_d;
         ss_armed_q  <= ss_armed_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         addr_q      <= addr_d;
         quad_q      <= quad_d;
         nxt_byte_q  <= nxt_byte_d;
         rd_pend_q   <= mem_rd_q;
         out_sr_q    <= out_sr_d;
         out_cnt_q   <= out_cnt_d;
         dq_q        <= dq_d;
         oe_q        <= oe_d;
         mem_rd_q    <= mem_rd_d;
         mem_addr_q  <= mem_addr_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   assign spi_dq0_o    = dq_q[0];
   assign spi_dq1_o    = dq_q[1];
   assign spi_dq2_o    = dq_q[2];
   assign spi_dq3_o    = dq_q[3];
   assign spi_dq0_oe_o = oe_q[0];
   assign spi_dq1_oe_o = oe_q[1];
   assign spi_dq2_oe_o = oe_q[2];
   assign spi_dq3_oe_o = oe_q[3];
   assign mem_rd_o     = mem_rd_q;
   assign mem_addr_o   = mem_addr_q;
   assign busy_o       = (state_q != IDLE);
   assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: acts as SPI initiator and as the byte store.
module tb_spi_flash_resp;

   localparam int HALF = 8;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic spi_clk_i = 1'b0;
   logic spi_ss_i = 1'b1;
   logic spi_dq0_i = 1'b0, spi_dq1_i = 1'b0, spi_dq2_i = 1'b0, spi_dq3_i = 1'b0;
   logic spi_dq0_o, spi_dq1_o, spi_dq2_o, spi_dq3_o;
   logic spi_dq0_oe_o, spi_dq1_oe_o, spi_dq2_oe_o, spi_dq3_oe_o;
   logic        mem_rd_o;
   logic [23:0] mem_addr_o;
   logic [7:0]  mem_rdata_i = 8'd0;
   logic        busy_o, cmd_err_o;

   int n_cmp = 0;
   int n_bad = 0;
   int err_cycles = 0;
   int oe_cycles = 0;
   logic [23:0] rd_log[$];

   logic [3:0] dq_bus, oe_bus;
   assign dq_bus = {spi_dq3_o, spi_dq2_o, spi_dq1_o, spi_dq0_o};
   assign oe_bus = {spi_dq3_oe_o, spi_dq2_oe_o, spi_dq1_oe_o, spi_dq0_oe_o};

   spi_flash_resp #(.SYNC_STAGES(2), .DUMMY_CYCLES(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .spi_clk_i(spi_clk_i), .spi_ss_i(spi_ss_i),
      .spi_dq0_i(spi_dq0_i), .spi_dq1_i(spi_dq1_i), .spi_dq2_i(spi_dq2_i), .spi_dq3_i(spi_dq3_i),
      .spi_dq0_o(spi_dq0_o), .spi_dq1_o(spi_dq1_o), .spi_dq2_o(spi_dq2_o), .spi_dq3_o(spi_dq3_o),
      .spi_dq0_oe_o(spi_dq0_oe_o), .spi_dq1_oe_o(spi_dq1_oe_o),
      .spi_dq2_oe_o(spi_dq2_oe_o), .spi_dq3_oe_o(spi_dq3_oe_o),
      .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .cmd_err_o(cmd_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] store(input logic [23:0] a);
      case (a)
         24'h000010: store = 8'hA5;
         24'h000011: store = 8'h3C;
         24'h000020: store = 8'h5A;
         24'h000021: store = 8'h96;
         24'hFFFFFF: store = 8'h81;
         24'h000000: store = 8'h7E;
         24'h000004: store = 8'hC3;
         default:    store = a[7:0] ^ 8'h55;
      endcase
   endfunction

   // Byte store with one-cycle read latency, plus activity monitors
   always @(posedge clk_i) begin
      if (mem_rd_o) begin
         mem_rdata_i <= store(mem_addr_o);
         rd_log.push_back(mem_addr_o);
      end
      if (cmd_err_o) err_cycles++;
      if (|oe_bus) oe_cycles++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic half_period();
      repeat (HALF) @(negedge clk_i);
   endtask

   task automatic spi_bit(input logic d0, output logic [3:0] dq, output logic [3:0] oe);
      spi_dq0_i = d0;
      half_period();
      dq = dq_bus;
      oe = oe_bus;
      spi_clk_i = 1'b1;
      half_period();
      spi_clk_i = 1'b0;
   endtask

   task automatic ss_start();
      spi_ss_i = 1'b0;
      repeat (6) @(negedge clk_i);
   endtask

   task automatic ss_end();
      half_period();
      spi_ss_i = 1'b1;
      repeat (8) @(negedge clk_i);
   endtask

   task automatic send_bits(input logic [23:0] v, input int n);
      logic [3:0] dq, oe;
      for (int i = n - 1; i >= 0; i--) spi_bit(v[i], dq, oe);
   endtask

   task automatic read_single(input int nbits, output logic [15:0] bits, output logic oe_ok);
      logic [3:0] dq, oe;
      bits = 16'd0;
      oe_ok = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         spi_bit(1'b0, dq, oe);
         bits = {bits[14:0], dq[1]};
         if (oe !== 4'b0010) oe_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      n_cmp++;
      if ({dq_bus, oe_bus, mem_rd_o, mem_addr_o, cmd_err_o} !== 33'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0", {dq_bus, oe_bus, mem_rd_o, mem_addr_o, cmd_err_o});
      end
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy: got %b expected 0", busy_o);
      end
      rst_i = 1'b0;
      repeat (8) @(negedge clk_i);
   endtask

   task automatic test_single_read();
      logic [15:0] bits;
      logic oe_ok;
      int base = rd_log.size();
      ss_start();
      n_cmp++;
      if (busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL single_busy: got %b expected 1", busy_o);
      end
      send_bits(24'h03, 8);
      send_bits(24'h000010, 24);
      read_single(16, bits, oe_ok);
      n_cmp++;
      if (bits !== 16'hA53C) begin
         n_bad++;
         $display("FAIL single_data: got %h expected a53c", bits);
      end
      n_cmp++;
      if (oe_ok !== 1'b1) begin
         n_bad++;
         $display("FAIL single_oe: got bad oe pattern, expected only dq1 driven");
      end
      n_cmp++;
      if (rd_log.size() < base + 2) begin
         n_bad++;
         $display("FAIL single_rd_count: got %0d expected >= 2", rd_log.size() - base);
      end else if (rd_log[base] !== 24'h10 || rd_log[base+1] !== 24'h11) begin
         n_bad++;
         $display("FAIL single_rd_addr: got %h,%h expected 000010,000011", rd_log[base], rd_log[base+1]);
      end
      ss_end();
      n_cmp++;
      if ({busy_o, oe_bus} !== 5'd0) begin
         n_bad++;
         $display("FAIL single_release: got busy/oe %b expected 0", {busy_o, oe_bus});
      end
   endtask

   task automatic test_quad_read();
      logic [3:0] dq, oe, n1, n2, oe1, oe2;
      logic dummy_ok = 1'b1;
      ss_start();
      send_bits(24'h6B, 8);
      send_bits(24'h000020, 24);
      for (int i = 0; i < 8; i++) begin
         spi_bit(1'b0, dq, oe);
         if (oe !== 4'b0000) dummy_ok = 1'b0;
      end
      spi_bit(1'b0, n1, oe1);
      spi_bit(1'b0, n2, oe2);
      ss_end();
      n_cmp++;
      if (dummy_ok !== 1'b1) begin
         n_bad++;
         $display("FAIL quad_dummy_oe: got oe asserted during dummy, expected 0");
      end
      n_cmp++;
      if ({n1, n2} !== 8'h5A) begin
         n_bad++;
         $display("FAIL quad_data: got %h expected 5a", {n1, n2});
      end
      n_cmp++;
      if ({oe1, oe2} !== 8'hFF) begin
         n_bad++;
         $display("FAIL quad_oe: got %h expected ff", {oe1, oe2});
      end
   endtask

   task automatic test_wrap();
      logic [15:0] bits;
      logic oe_ok;
      int base = rd_log.size();
      ss_start();
      send_bits(24'h03, 8);
      send_bits(24'hFFFFFF, 24);
      read_single(16, bits, oe_ok);
      ss_end();
      n_cmp++;
      if (bits !== 16'h817E) begin
         n_bad++;
         $display("FAIL wrap_data: got %h expected 817e", bits);
      end
      n_cmp++;
      if (rd_log.size() < base + 2) begin
         n_bad++;
         $display("FAIL wrap_rd_count: got %0d expected >= 2", rd_log.size() - base);
      end else if (rd_log[base+1] !== 24'h000000) begin
         n_bad++;
         $display("FAIL wrap_addr: got %h expected 000000", rd_log[base+1]);
      end
   endtask

   task automatic test_bad_cmd();
      logic [15:0] bits;
      logic oe_ok;
      int e0 = err_cycles;
      int o0 = oe_cycles;
      ss_start();
      send_bits(24'h9F, 8);
      send_bits(24'h00FF00, 16);
      ss_end();
      n_cmp++;
      if (err_cycles - e0 != 1) begin
         n_bad++;
         $display("FAIL bad_cmd_err: got %0d pulse cycles expected 1", err_cycles - e0);
      end
      n_cmp++;
      if (oe_cycles - o0 != 0) begin
         n_bad++;
         $display("FAIL bad_cmd_oe: got %0d driven cycles expected 0", oe_cycles - o0);
      end
      ss_start();
      send_bits(24'h03, 8);
      send_bits(24'h000010, 24);
      read_single(8, bits, oe_ok);
      ss_end();
      n_cmp++;
      if (bits[7:0] !== 8'hA5) begin
         n_bad++;
         $display("FAIL bad_cmd_recover: got %h expected a5", bits[7:0]);
      end
   endtask

   task automatic test_abort();
      logic [15:0] bits;
      logic oe_ok;
      int base = rd_log.size();
      ss_start();
      send_bits(24'h03, 8);
      send_bits(24'h000ABC, 12);
      ss_end();
      n_cmp++;
      if (rd_log.size() != base) begin
         n_bad++;
         $display("FAIL abort_no_read: got %0d reads expected 0", rd_log.size() - base);
      end
      ss_start();
      send_bits(24'h03, 8);
      send_bits(24'h000004, 24);
      read_single(8, bits, oe_ok);
      ss_end();
      n_cmp++;
      if (bits[7:0] !== 8'hC3) begin
         n_bad++;
         $display("FAIL abort_data: got %h expected c3", bits[7:0]);
      end
      n_cmp++;
      if (rd_log.size() <= base || rd_log[base] !== 24'h000004) begin
         n_bad++;
         $display("FAIL abort_addr: got %0d reads expected first at 000004", rd_log.size() - base);
      end
   endtask

   task automatic test_reset_in_data();
      logic [15:0] bits;
      logic oe_ok;
      ss_start();
      send_bits(24'h03, 8);
      send_bits(24'h000010, 24);
      read_single(4, bits, oe_ok);
      rst_i = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if ({dq_bus, oe_bus, mem_rd_o, mem_addr_o, cmd_err_o, busy_o} !== 34'd0) begin
         n_bad++;
         $display("FAIL rst_data_outputs: got %h expected 0",
                  {dq_bus, oe_bus, mem_rd_o, mem_addr_o, cmd_err_o, busy_o});
      end
      rst_i = 1'b0;
      repeat (12) @(negedge clk_i);
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_no_stale_ss: got busy %b expected 0", busy_o);
      end
      spi_ss_i = 1'b1;
      repeat (8) @(negedge clk_i);
      ss_start();
      send_bits(24'h03, 8);
      send_bits(24'h000011, 24);
      read_single(8, bits, oe_ok);
      ss_end();
      n_cmp++;
      if (bits[7:0] !== 8'h3C) begin
         n_bad++;
         $display("FAIL rst_recover: got %h expected 3c", bits[7:0]);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_quad_read();
      test_wrap();
      test_bad_cmd();
      test_abort();
      test_reset_in_data();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
